// File: rtl/sm_subtractor_pipe.sv
// Two-stage sign-magnitude subtractor, S = A - B, with valid/ready on both sides.
// Stage 1 captures signs and magnitudes with B negated. Stage 2 adds or subtracts the magnitudes and normalises -0.
module sm_subtractor_pipe #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] S,
    output logic         ovf
);

    typedef struct packed {
        logic         sa;
        logic         sb;
        logic         ge;
        logic [N-2:0] ma;
        logic [N-2:0] mb;
    } prep_t;

    prep_t        s1;
    logic [2:1]   vld_pipe;
    logic         in_fire;
    logic         s2_load;
    logic [N-1:0] sum;
    logic [N-2:0] r_mag;
    logic         r_sign;
    logic         r_ovf;

    // Stage 2 frees up whenever it is empty or draining, so stage 1 can always move forward into it.
    assign s2_load   = vld_pipe[1] && (!vld_pipe[2] || out_ready);
    assign in_ready  = !vld_pipe[1] || !vld_pipe[2] || out_ready;
    assign in_fire   = in_valid && in_ready;
    assign out_valid = vld_pipe[2];
    assign sum       = {1'b0, s1.ma} + {1'b0, s1.mb};

    always_comb begin
        r_mag  = '0;
        r_sign = 1'b0;
        r_ovf  = 1'b0;
        if (s1.sa == s1.sb) begin
            r_mag  = sum[N-2:0];
            r_sign = s1.sa;
            r_ovf  = sum[N-1];
        end else if (s1.ge) begin
            r_mag  = s1.ma - s1.mb;
            r_sign = s1.sa;
        end else begin
            r_mag  = s1.mb - s1.ma;
            r_sign = s1.sb;
        end
        // A zero magnitude always gets a positive sign. This also covers -0 inputs and a wrapped overflow result.
        if (r_mag == '0)
            r_sign = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1       <= '0;
            vld_pipe <= '0;
            S        <= '0;
            ovf      <= 1'b0;
        end else begin
            if (in_fire)
                s1 <= '{sa: A[N-1], sb: ~B[N-1], ge: (A[N-2:0] >= B[N-2:0]),
                        ma: A[N-2:0], mb: B[N-2:0]};
            if (in_fire)
                vld_pipe[1] <= 1'b1;
            else if (s2_load)
                vld_pipe[1] <= 1'b0;
            if (s2_load)
                vld_pipe[2] <= 1'b1;
            else if (out_ready)
                vld_pipe[2] <= 1'b0;
            if (s2_load) begin
                S   <= {r_sign, r_mag};
                ovf <= r_ovf;
            end
        end
    end

endmodule

// File: tb/tb_sm_subtractor_pipe.sv
// Random and directed stimulus for sm_subtractor_pipe.
// Results are checked against an integer-arithmetic model and a queue of in-flight pairs.
module tb_sm_subtractor_pipe;
    localparam int N  = 8;
    localparam int MW = N - 1;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] S;
    logic         ovf;

    sm_subtractor_pipe #(.N(N)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .out_valid(out_valid), .out_ready(out_ready), .S(S), .ovf(ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N:0] res;
        int         acc;
    } item_t;

    item_t      q[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc    = 0;
    logic       hold_pending = 1'b0;
    logic [N:0] held;
    logic       last_in_fire;

    // Returns {ovf, S}, computed from the signed values and not from bit fields.
    function automatic logic [N:0] model(logic [N-1:0] a, logic [N-1:0] b);
        int va, vb, d, mag, m;
        logic sg;
        va  = a[N-1] ? -int'(a[N-2:0]) : int'(a[N-2:0]);
        vb  = b[N-1] ? -int'(b[N-2:0]) : int'(b[N-2:0]);
        d   = va - vb;
        mag = (d < 0) ? -d : d;
        m   = mag % (1 << MW);
        sg  = (d < 0) && (m != 0);
        return {(mag >= (1 << MW)), sg, MW'(m)};
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Called at a negedge after the inputs are driven. It checks this cycle, records transfers and advances one clock.
    task automatic cycle_chk();
        logic exp_vld;
        #1;
        exp_vld = (q.size() > 0) && (q[0].acc + 1 <= cyc);
        chk("out_valid", 32'(out_valid), 32'(exp_vld));
        chk("in_ready", 32'(in_ready), 32'((q.size() < 2) || out_ready));
        if (hold_pending && out_valid)
            chk("hold_S_ovf", 32'({ovf, S}), 32'(held));
        if (out_valid && out_ready) begin
            if (q.size() > 0) begin
                chk("result", 32'({ovf, S}), 32'(q[0].res));
                void'(q.pop_front());
            end else begin
                chk("spurious_result", 32'(out_valid), 32'(0));
            end
        end
        hold_pending = out_valid && !out_ready;
        held         = {ovf, S};
        last_in_fire = in_valid && in_ready;
        if (last_in_fire)
            q.push_back('{res: model(A, B), acc: cyc + 1});
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic send(logic [N-1:0] a, logic [N-1:0] b);
        int tries = 0;
        in_valid = 1'b1;
        A = a;
        B = b;
        do begin
            cycle_chk();
            tries++;
        end while (!last_in_fire && tries < 20);
        if (!last_in_fire)
            chk("send_timeout", 32'(0), 32'(1));
        in_valid = 1'b0;
    endtask

    task automatic idle(int n, logic rdy);
        out_ready = rdy;
        for (int i = 0; i < n; i++)
            cycle_chk();
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; A = '0; B = '0;

        // Pin the model with hand-computed results.
        chk("model_70m-30",  32'(model(8'b01000110, 8'b10011110)), 32'(9'b0_01100100));
        chk("model_-56m13",  32'(model(8'b10111000, 8'b00001101)), 32'(9'b0_11000101));
        chk("model_20m47",   32'(model(8'b00010100, 8'b00101111)), 32'(9'b0_10011011));
        chk("model_ovf",     32'(model(8'b01100100, 8'b10110010)), 32'(9'b1_00010110));
        chk("model_eq",      32'(model(8'b00100010, 8'b00100010)), 32'(9'b0_00000000));
        chk("model_negzero", 32'(model(8'b10000000, 8'b00000000)), 32'(9'b0_00000000));

        @(negedge clk);
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'(0));
        chk("rst_S_ovf", 32'({ovf, S}), 32'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // Directed vectors, with the 2-cycle latency checked by the scoreboard.
        out_ready = 1'b1;
        send(8'b01000110, 8'b10011110);
        idle(3, 1'b1);
        send(8'b10111000, 8'b00001101);
        send(8'b00010100, 8'b00101111);
        send(8'b01100100, 8'b10110010);
        send(8'b00100010, 8'b00100010);
        send(8'b10000000, 8'b00000000);
        idle(3, 1'b1);

        // Back-to-back stream, then backpressure.
        for (int i = 0; i < 4; i++)
            send(N'($urandom), N'($urandom));
        idle(3, 1'b1);
        out_ready = 1'b0;
        send(N'($urandom), N'($urandom));
        send(N'($urandom), N'($urandom));
        in_valid = 1'b1; A = N'($urandom); B = N'($urandom);
        for (int i = 0; i < 3; i++)
            cycle_chk();
        in_valid = 1'b0;
        idle(5, 1'b1);

        // Reset with both stages full.
        out_ready = 1'b0;
        send(N'($urandom), N'($urandom));
        send(N'($urandom), N'($urandom));
        cycle_chk();
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'(0));
        chk("midrst_S_ovf", 32'({ovf, S}), 32'(0));
        q.delete();
        hold_pending = 1'b0;
        @(posedge clk);
        cyc++;
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        send(8'b00000011, 8'b00000101);
        send(8'b10000001, 8'b10000001);
        idle(4, 1'b1);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            A = N'($urandom);
            B = N'($urandom);
            cycle_chk();
        end
        in_valid = 1'b0;
        idle(5, 1'b1);
        chk("drained", 32'(q.size()), 32'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
